io_ccff_loader: RTL and testbench

IO_CCFF_LOADER -- requirements
Module: io_ccff_loader

---
 rtl/io_ccff_loader_if.sv | 12 +
 rtl/io_ccff_loader.sv | 192 +++++++++++++++++++
 tb/tb_io_ccff_loader.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_ccff_loader_if.sv
// Host bitstream stream channel: the host offers words with s_valid/s_data,
// and the loader accepts a word in any cycle where s_valid and s_ready are both high.
interface io_ccff_loader_if #(
   parameter int WORD_W = 8
) ();
   logic              s_valid;
   logic              s_ready;
   logic [WORD_W-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/io_ccff_loader.sv
// io_ccff_loader: shifts a host bitstream into an IO tile configuration flop
// chain. An optional second pass reads the chain back and compares it against
// the stream. IOs stay isolated until a load completes without errors.
module io_ccff_loader #(
   parameter int CHAIN_LEN = 4,
   parameter int WORD_W    = 8,
   parameter int SETTLE    = 2
) (
   input  logic                           prog_clk,
   input  logic                           prog_reset,
   input  logic                           start_i,
   input  logic                           verify_i,
   io_ccff_loader_if.slave                s_if,
   output logic                           ccff_head_o,
   input  logic                           ccff_tail_i,
   output logic                           chain_shift_en_o,
   output logic                           isol_n_o,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           error_o,
   output logic [$clog2(CHAIN_LEN+1)-1:0] mismatch_cnt_o
);
   localparam int BCW = $clog2(CHAIN_LEN + 1);
   localparam int WCW = $clog2(WORD_W + 1);
   localparam int SCW = $clog2(SETTLE + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISOLATE = 3'd1,
      ST_LOAD    = 3'd2,
      ST_SHIFT   = 3'd3,
      ST_SETTLE  = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   state_t             state_q,    state_d;
   logic [WORD_W-1:0]  sr_q,       sr_d;
   logic [BCW-1:0]     bit_cnt_q,  bit_cnt_d;
   logic [WCW-1:0]     word_bit_q, word_bit_d;
   logic [SCW-1:0]     settle_q,   settle_d;
   logic [BCW-1:0]     mm_q,       mm_d;
   logic               pass2_q,    pass2_d;
   logic               verify_q,   verify_d;
   logic               error_q,    error_d;
   logic               isol_q,     isol_d;
   // Outputs are registered from the next-state decode so they change cleanly on the edge.
   logic               s_ready_q,  s_ready_d;
   logic               shift_q,    shift_d;
   logic               head_q,     head_d;
   logic               busy_q,     busy_d;
   logic               done_q,     done_d;

   // State, datapath and output registers; synchronous reset returns everything to idle/isolated.
   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_q    <= ST_IDLE;
         sr_q       <= '0;
         bit_cnt_q  <= '0;
         word_bit_q <= '0;
         settle_q   <= '0;
         mm_q       <= '0;
         pass2_q    <= 1'b0;
         verify_q   <= 1'b0;
         error_q    <= 1'b0;
         isol_q     <= 1'b0;
         s_ready_q  <= 1'b0;
         shift_q    <= 1'b0;
         head_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         bit_cnt_q  <= bit_cnt_d;
         word_bit_q <= word_bit_d;
         settle_q   <= settle_d;
         mm_q       <= mm_d;
         pass2_q    <= pass2_d;
         verify_q   <= verify_d;
         error_q    <= error_d;
         isol_q     <= isol_d;
         s_ready_q  <= s_ready_d;
         shift_q    <= shift_d;
         head_q     <= head_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next-state, datapath and next-output decode for the load sequence.
   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      bit_cnt_d  = bit_cnt_q;
      word_bit_d = word_bit_q;
      settle_d   = settle_q;
      mm_d       = mm_q;
      pass2_d    = pass2_q;
      verify_d   = verify_q;
      error_d    = error_q;
      isol_d     = isol_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d    = ST_ISOLATE;
               error_d    = 1'b0;
               mm_d       = '0;
               verify_d   = verify_i;
               pass2_d    = 1'b0;
               bit_cnt_d  = '0;
               word_bit_d = '0;
               isol_d     = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISOLATE: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (s_if.s_valid && s_ready_q) begin
               sr_d       = s_if.s_data;
               word_bit_d = '0;
               state_d    = ST_SHIFT;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_SHIFT: begin
            sr_d       = sr_q >> 1;
            bit_cnt_d  = bit_cnt_q + BCW'(1);
            word_bit_d = word_bit_q + WCW'(1);
            // Readback pass: the tail must replay the first pass while the same stream is re-sent.
            if (pass2_q && (ccff_tail_i != head_q)) begin
               error_d = 1'b1;
               if (mm_q != BCW'(CHAIN_LEN)) begin
                  mm_d = mm_q + BCW'(1);
               end else begin
                  mm_d = mm_q;
               end
            end else begin
               error_d = error_q;
            end
            // The chain-full condition wins over the word boundary, so leftover word bits are dropped.
            if (bit_cnt_q == BCW'(CHAIN_LEN - 1)) begin
               if (verify_q && !pass2_q) begin
                  bit_cnt_d = '0;
                  pass2_d   = 1'b1;
                  state_d   = ST_LOAD;
               end else begin
                  settle_d = '0;
                  state_d  = ST_SETTLE;
               end
            end else if (word_bit_q == WCW'(WORD_W - 1)) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_SETTLE: begin
            if (settle_q == SCW'(SETTLE - 1)) begin
               state_d = ST_DONE;
            end else begin
               settle_d = settle_q + SCW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            isol_d  = ~error_q;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      s_ready_d = (state_d == ST_LOAD);
      shift_d   = (state_d == ST_SHIFT);
      head_d    = shift_d & sr_d[0];
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);
   end

   assign s_if.s_ready     = s_ready_q;
   assign ccff_head_o      = head_q;
   assign chain_shift_en_o = shift_q;
   assign isol_n_o         = isol_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign error_o          = error_q;
   assign mismatch_cnt_o   = mm_q;
endmodule

// File: tb/tb_io_ccff_loader.sv
// Testbench for io_ccff_loader. It drives a default 4-flop tile and a
// 12-flop tile. An expected-bit stream model and an isolation model are
// checked every cycle, and literal timing and sequence expectations are also checked.
module tb_io_ccff_loader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b1, start_a = 1'b0, verify_a = 1'b0;
   logic rst_b = 1'b1, start_b = 1'b0, verify_b = 1'b0;
   logic a_head, a_tail, a_sen, a_isol, a_busy, a_done, a_err;
   logic b_head, b_tail, b_sen, b_isol, b_busy, b_done, b_err;
   logic [2:0] a_mm;
   logic [3:0] b_mm;

   io_ccff_loader_if #(.WORD_W(8)) ha ();
   io_ccff_loader_if #(.WORD_W(8)) hb ();

   io_ccff_loader #(.CHAIN_LEN(4), .WORD_W(8), .SETTLE(2)) dut_a (
      .prog_clk(clk), .prog_reset(rst_a), .start_i(start_a), .verify_i(verify_a),
      .s_if(ha), .ccff_head_o(a_head), .ccff_tail_i(a_tail), .chain_shift_en_o(a_sen),
      .isol_n_o(a_isol), .busy_o(a_busy), .done_o(a_done), .error_o(a_err),
      .mismatch_cnt_o(a_mm));

   io_ccff_loader #(.CHAIN_LEN(12), .WORD_W(8), .SETTLE(2)) dut_b (
      .prog_clk(clk), .prog_reset(rst_b), .start_i(start_b), .verify_i(verify_b),
      .s_if(hb), .ccff_head_o(b_head), .ccff_tail_i(b_tail), .chain_shift_en_o(b_sen),
      .isol_n_o(b_isol), .busy_o(b_busy), .done_o(b_done), .error_o(b_err),
      .mismatch_cnt_o(b_mm));

   // Physical chain models: head enters flop 0, tail is the last flop.
   logic [3:0]  chain_a = '0;
   logic [11:0] chain_b = '0;
   always @(posedge clk) begin
      if (a_sen) chain_a <= {chain_a[2:0], a_head};
      if (b_sen) chain_b <= {chain_b[10:0], b_head};
   end
   assign a_tail = chain_a[3];
   assign b_tail = chain_b[11];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int  n_checks = 0;
   int  n_fail   = 0;
   bit  chk_en   = 1'b0;
   bit  exp_a[$];
   bit  exp_b[$];
   int  exp_mm   = 0;
   bit  exp_err  = 1'b0;
   bit  isol_model = 1'b0;
   logic [11:0] b_seen = '0;
   int  b_cnt = 0;
   bit  log_sen[256], log_head[256], log_rdy[256], log_done[256], log_busy[256], log_isol[256];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle comparison of both loaders against the stream and isolation models.
   always @(negedge clk) begin
      if (chk_en) begin
         if (a_sen) begin
            chk("a_shift_expected", (exp_a.size() != 0), 1);
            if (exp_a.size() != 0) chk("a_head", a_head, exp_a.pop_front());
         end else begin
            chk("a_head_idle", a_head, 0);
         end
         if (a_busy) chk("a_isol_busy", a_isol, 0);
         else        chk("a_isol", a_isol, isol_model);
         if (a_done) begin
            chk("a_bits_left", exp_a.size(), 0);
            chk("a_error", a_err, exp_err);
            chk("a_mismatch_cnt", a_mm, exp_mm);
            isol_model = !exp_err;
         end
         if (rst_a) begin
            exp_a.delete();
            isol_model = 1'b0;
         end
         if (b_sen) begin
            chk("b_shift_expected", (exp_b.size() != 0), 1);
            if (exp_b.size() != 0) chk("b_head", b_head, exp_b.pop_front());
            b_seen = {b_seen[10:0], b_head};
            b_cnt++;
         end else begin
            chk("b_head_idle", b_head, 0);
         end
      end
      log_sen[cyc & 255]  = a_sen;
      log_head[cyc & 255] = a_head;
      log_rdy[cyc & 255]  = ha.s_ready;
      log_done[cyc & 255] = a_done;
      log_busy[cyc & 255] = a_busy;
      log_isol[cyc & 255] = a_isol;
   end

   function automatic logic [11:0] grab(input int c0, input int which);
      logic [11:0] v;
      v = '0;
      for (int k = 0; k < 12; k++) begin
         case (which)
            0:       v[k] = log_sen[(c0 + k) & 255];
            1:       v[k] = log_head[(c0 + k) & 255];
            2:       v[k] = log_rdy[(c0 + k) & 255];
            3:       v[k] = log_done[(c0 + k) & 255];
            4:       v[k] = log_busy[(c0 + k) & 255];
            default: v[k] = log_isol[(c0 + k) & 255];
         endcase
      end
      return v;
   endfunction

   task automatic send_word_a(input logic [7:0] w, input int gap);
      int n;
      n = 0;
      while (!ha.s_ready && n < 40) begin tick(); n++; end
      chk("a_ready_wait", (n < 40), 1);
      for (int i = 0; i < gap; i++) begin
         start_a  = (i == 0);   // a start while busy must be ignored
         verify_a = (i == 0);
         tick();
      end
      start_a = 1'b0; verify_a = 1'b0;
      ha.s_valid = 1'b1; ha.s_data = w;
      tick();
      ha.s_valid = 1'b0;
   endtask

   task automatic load_a(input bit vfy, input logic [7:0] w1, input logic [7:0] w2,
                         input int gap, output int c0, output int c_done);
      int mm;
      int n;
      mm = 0;
      for (int k = 0; k < 4; k++) exp_a.push_back(w1[k]);
      if (vfy) begin
         for (int k = 0; k < 4; k++) begin
            exp_a.push_back(w2[k]);
            if (w1[k] != w2[k]) mm++;
         end
      end
      exp_mm  = (mm > 4) ? 4 : mm;
      exp_err = (mm != 0);
      c0 = cyc;
      start_a = 1'b1; verify_a = vfy;
      tick();
      start_a = 1'b0; verify_a = 1'b0;
      send_word_a(w1, gap);
      if (vfy) send_word_a(w2, 0);
      n = 0;
      while (!a_done && n < 60) begin tick(); n++; end
      chk("a_done_wait", (n < 60), 1);
      c_done = cyc;
      tick();
   endtask

   initial begin
      int c0, cd, n;
      logic [7:0] wb1, wb2, w0b;
      ha.s_valid = 1'b0; ha.s_data = '0;
      hb.s_valid = 1'b0; hb.s_data = '0;
      repeat (3) tick();
      chk_en = 1'b1;
      chk("reset_a_outputs", {a_sen, a_head, a_busy, a_done, a_err, a_isol, ha.s_ready, a_mm}, 0);
      chk("reset_b_outputs", {b_sen, b_head, b_busy, b_done, b_err, b_isol, hb.s_ready, b_mm}, 0);
      rst_a = 1'b0; rst_b = 1'b0;
      tick();

      // Basic load of 0x0B with exact cycle timing.
      load_a(1'b0, 8'h0B, 8'h00, 0, c0, cd);
      repeat (2) tick();
      chk("t037_shift_en", grab(c0, 0), 12'h078);
      chk("t037_head",     grab(c0, 1), 12'h058);
      chk("t037_s_ready",  grab(c0, 2), 12'h004);
      chk("t037_done",     grab(c0, 3), 12'h200);
      chk("t037_busy",     grab(c0, 4), 12'h3FE);
      chk("t037_isol_n",   grab(c0, 5), 12'hC00);

      // Host gap of five LOAD cycles, with a stray start+verify while busy.
      load_a(1'b0, 8'h0B, 8'h00, 5, c0, cd);
      chk("t038_done_cycle", cd - c0, 14);

      // Verify pass with identical stream.
      load_a(1'b1, 8'h0B, 8'h0B, 0, c0, cd);
      chk("t040_mm", a_mm, 0);
      chk("t040_isol_n", a_isol, 1);

      // Verify pass with one bit wrong.
      load_a(1'b1, 8'h0B, 8'h0A, 0, c0, cd);
      chk("t041_mm", a_mm, 1);
      chk("t041_error", a_err, 1);
      chk("t041_isol_n", a_isol, 0);

      // Every readback bit wrong: count reaches the chain length.
      load_a(1'b1, 8'h0B, 8'h04, 0, c0, cd);
      chk("sat_mm", a_mm, 4);
      chk("sat_isol_n", a_isol, 0);

      // A later error-free load releases isolation again.
      load_a(1'b1, 8'h06, 8'h06, 0, c0, cd);
      chk("recover_isol_n", a_isol, 1);
      chk("recover_error", a_err, 0);

      // Reset during the third shift aborts the load.
      w0b = 8'h0B;
      for (int k = 0; k < 4; k++) exp_a.push_back(w0b[k]);
      start_a = 1'b1; verify_a = 1'b0;
      tick();
      start_a = 1'b0;
      ha.s_valid = 1'b1; ha.s_data = w0b;
      n = 0;
      while (!a_sen && n < 40) begin tick(); n++; end
      chk("t042_shift_wait", (n < 40), 1);
      ha.s_valid = 1'b0;
      repeat (2) tick();
      rst_a = 1'b1;
      tick();
      chk("t042_reset_outputs", {a_sen, a_head, a_busy, a_done, a_err, a_isol, ha.s_ready, a_mm}, 0);
      tick();
      rst_a = 1'b0;
      repeat (3) tick();
      chk("t042_idle_after", {a_sen, a_busy, a_isol}, 0);
      load_a(1'b0, 8'h0B, 8'h00, 0, c0, cd);
      chk("t042_reload_cycles", cd - c0, 9);
      chk("t042_isol_n", a_isol, 1);

      // 12-flop chain, two words, surplus word kept on offer.
      wb1 = 8'hA5; wb2 = 8'h03;
      for (int k = 0; k < 8; k++) exp_b.push_back(wb1[k]);
      for (int k = 0; k < 4; k++) exp_b.push_back(wb2[k]);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int w = 0; w < 2; w++) begin
         n = 0;
         while (!hb.s_ready && n < 40) begin tick(); n++; end
         chk("b_ready_wait", (n < 40), 1);
         hb.s_valid = 1'b1; hb.s_data = (w == 0) ? wb1 : wb2;
         tick();
      end
      hb.s_data = 8'hFF;
      n = 0;
      while (!b_done && n < 60) begin tick(); n++; end
      chk("b_done_wait", (n < 60), 1);
      hb.s_valid = 1'b0;
      repeat (2) tick();
      chk("t039_shift_count", b_cnt, 12);
      chk("t039_head_seq", b_seen, 12'hA5C);
      chk("t039_isol_n", b_isol, 1);
      chk("t039_error", b_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end
endmodule
